// File: rtl/spi_pico_frame_ctrl_if.sv
// Bus bundle for spi_pico_frame_ctrl: raw SPI PICO inputs plus the register-bank
// write port, mux select and frame status outputs.
interface spi_pico_frame_ctrl_if #(
  parameter int WORD_W = 8
) ();
  logic              sclk;
  logic              serial_in;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] write_addr;
  logic              write_en;
  logic [WORD_W-1:0] mux_control_signal;
  logic              busy;
  logic              frame_done;
  logic              addr_err;

  modport master (
    output sclk, serial_in,
    input  write_data, write_addr, write_en, mux_control_signal,
    input  busy, frame_done, addr_err
  );

  modport slave (
    input  sclk, serial_in,
    output write_data, write_addr, write_en, mux_control_signal,
    output busy, frame_done, addr_err
  );
endinterface

// File: rtl/spi_pico_frame_ctrl.sv
// SPI PICO frame receiver: first word is a register address, later words are writes.
// Define PICO_AUTOINC_EN to advance the address pointer after every data word.
module spi_pico_frame_ctrl #(
  parameter int WORD_W         = 8,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  iclk,
  input  logic                  rst,
  spi_pico_frame_ctrl_if.slave  bus
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [WORD_W:0]   REG_LIMIT = (WORD_W + 1)'(NUM_REGS);
`ifdef PICO_AUTOINC_EN
  localparam logic [WORD_W-1:0] LAST_REG  = WORD_W'(NUM_REGS - 1);
`endif

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] dataSync_q;
  logic                   sclkDly_q;

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [TO_W-1:0]   toCnt_q,  toCnt_d;
  logic [WORD_W-1:0] shift_q,  shift_d;
  logic [WORD_W-1:0] ptr_q,    ptr_d;
  logic [WORD_W-1:0] wAddr_q,  wAddr_d;
  logic [WORD_W-1:0] wData_q,  wData_d;
  logic              wEn_q,    wEn_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;

  logic              capture;
  logic              wordDone;
  logic [WORD_W-1:0] wordNow;
  logic              ptrInRange;
  logic              newInRange;

  // sclk is only data here: synchronise it and find rising edges in the iclk domain
  always_ff @(posedge iclk) begin
    if (rst) begin
      sclkSync_q <= '0;
      dataSync_q <= '0;
      sclkDly_q  <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], bus.serial_in};
      sclkDly_q  <= sclkSync_q[SYNC_STAGES-1];
    end
  end

  assign capture    = sclkSync_q[SYNC_STAGES-1] & ~sclkDly_q;
  assign wordNow    = {shift_q[WORD_W-2:0], dataSync_q[SYNC_STAGES-1]};
  assign wordDone   = capture && (bitCnt_q == LAST_BIT);
  assign ptrInRange = ({1'b0, ptr_q} < REG_LIMIT);
  assign newInRange = ({1'b0, wordNow} < REG_LIMIT);

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    toCnt_d  = toCnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    wAddr_d  = wAddr_q;
    wData_d  = wData_q;
    wEn_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d  = ADDR;
          shift_d  = wordNow;
          bitCnt_d = CNT_W'(1);
          toCnt_d  = '0;
        end
      end
      ADDR, DATA: begin
        // A capture always wins over the timeout because it restarts the idle count
        if (capture) begin
          toCnt_d = '0;
          shift_d = wordNow;
          if (wordDone) begin
            bitCnt_d = '0;
            if (state_q == ADDR) begin
              ptr_d   = wordNow;
              err_d   = ~newInRange;
              state_d = DATA;
            end else begin
              wAddr_d = ptr_q;
              wData_d = wordNow;
              if (ptrInRange) wEn_d = 1'b1;
              else            err_d = 1'b1;
`ifdef PICO_AUTOINC_EN
              ptr_d = (ptr_q == LAST_REG) ? '0 : ptr_q + WORD_W'(1);
`endif
            end
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end else if (toCnt_q == TO_LIMIT) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          bitCnt_d = '0;
          toCnt_d  = '0;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        bitCnt_d = '0;
        toCnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      toCnt_q  <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      wAddr_q  <= '0;
      wData_q  <= '0;
      wEn_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      toCnt_q  <= toCnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      wAddr_q  <= wAddr_d;
      wData_q  <= wData_d;
      wEn_q    <= wEn_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.write_data         = wData_q;
  assign bus.write_addr         = wAddr_q;
  assign bus.write_en           = wEn_q;
  assign bus.mux_control_signal = ptr_q;
  assign bus.busy               = (state_q != IDLE);
  assign bus.frame_done         = done_q;
  assign bus.addr_err           = err_q;

endmodule

// File: tb/tb_spi_pico_frame_ctrl.sv
// Self-checking bench for spi_pico_frame_ctrl: directed frames plus random frames
// checked against a word-level model of the address/write rules.
module tb_spi_pico_frame_ctrl;
  localparam int W  = 8;
  localparam int NR = 16;
  localparam int TO = 8;
  localparam int SS = 2;

  logic iclk = 1'b0;
  logic rst  = 1'b1;

  spi_pico_frame_ctrl_if #(.WORD_W(W)) bus ();

  spi_pico_frame_ctrl #(
    .WORD_W(W), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)
  ) dut (
    .iclk(iclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] gotQ[$];
  logic [2*W-1:0] expQ[$];
  logic [W-1:0]   txWords[$];
  int             doneCnt;
  int             expMux;
  logic           expErr;

  // Collects every write strobe and frame_done pulse the DUT produces
  always @(negedge iclk) begin
    if (bus.write_en === 1'b1) gotQ.push_back({bus.write_addr, bus.write_data});
    if (bus.frame_done === 1'b1) doneCnt++;
  end

  task automatic sendBit(input logic b);
    bus.sclk      = 1'b0;
    bus.serial_in = b;
    repeat (SS + 1) @(negedge iclk);
    bus.sclk = 1'b1;
    repeat (SS + 1) @(negedge iclk);
  endtask

  // Sends txWords MSB first, then stray bits, then lets the frame time out
  task automatic applyStimulus(input int extraBits);
    gotQ.delete();
    doneCnt = 0;
    @(negedge iclk);
    foreach (txWords[i]) begin
      for (int b = W - 1; b >= 0; b--) sendBit(txWords[i][b]);
    end
    for (int k = 0; k < extraBits; k++) sendBit(1'($urandom_range(0, 1)));
    bus.sclk = 1'b0;
    repeat (TO + SS + 12) @(negedge iclk);
  endtask

  // Reference: address word sets the pointer, each whole data word is one write
  task automatic buildExpect();
    int ptr;
    ptr    = int'(txWords[0]);
    expErr = (ptr >= NR);
    expQ.delete();
    for (int i = 1; i < txWords.size(); i++) begin
      if (ptr < NR) expQ.push_back({W'(ptr), txWords[i]});
      else          expErr = 1'b1;
`ifdef PICO_AUTOINC_EN
      ptr = (ptr == NR - 1) ? 0 : (ptr + 1) % (1 << W);
`endif
    end
    expMux = ptr;
  endtask

  task automatic test_reset();
    bus.sclk = 1'b0;
    bus.serial_in = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge iclk);
    total++; if (bus.write_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_write_en got=%b exp=0", bus.write_en); end
    total++; if (bus.write_data !== '0) begin bad++; $display("[TB] FAIL reset_write_data got=%h exp=0", bus.write_data); end
    total++; if (bus.write_addr !== '0) begin bad++; $display("[TB] FAIL reset_write_addr got=%h exp=0", bus.write_addr); end
    total++; if (bus.mux_control_signal !== '0) begin bad++; $display("[TB] FAIL reset_mux got=%h exp=0", bus.mux_control_signal); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_addr_err got=%b exp=0", bus.addr_err); end
    rst = 1'b0;
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_frame(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] d0, input logic [W-1:0] d1);
    txWords = '{a, d0, d1};
    applyStimulus(0);
    buildExpect();
    total++; if (gotQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL %s_count got=%0d exp=%0d", name, gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      total++; if (gotQ[i] !== expQ[i]) begin bad++; $display("[TB] FAIL %s_write%0d got=%h exp=%h", name, i, gotQ[i], expQ[i]); end
    end
    total++; if (bus.mux_control_signal !== W'(expMux)) begin bad++; $display("[TB] FAIL %s_mux got=%h exp=%h", name, bus.mux_control_signal, W'(expMux)); end
    total++; if (bus.addr_err !== expErr) begin bad++; $display("[TB] FAIL %s_addr_err got=%b exp=%b", name, bus.addr_err, expErr); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL %s_done_pulses got=%0d exp=1", name, doneCnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy got=%b exp=0", name, bus.busy); end
  endtask

  task automatic test_addr_err();
    txWords = '{8'h20, 8'hFF};
    applyStimulus(0);
    buildExpect();
    total++; if (gotQ.size() != 0) begin bad++; $display("[TB] FAIL adderr_writes got=%0d exp=0", gotQ.size()); end
    total++; if (bus.addr_err !== expErr) begin bad++; $display("[TB] FAIL adderr_set got=%b exp=%b", bus.addr_err, expErr); end
    txWords = '{8'h01};
    applyStimulus(0);
    buildExpect();
    total++; if (bus.addr_err !== expErr) begin bad++; $display("[TB] FAIL adderr_clear got=%b exp=%b", bus.addr_err, expErr); end
    total++; if (bus.mux_control_signal !== W'(expMux)) begin bad++; $display("[TB] FAIL adderr_mux got=%h exp=%h", bus.mux_control_signal, W'(expMux)); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL adderr_done_pulses got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_partial();
    txWords = '{8'h02, 8'h00};
    applyStimulus(5);
    buildExpect();
    total++; if (gotQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL partial_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    if (gotQ.size() > 0 && expQ.size() > 0) begin
      total++; if (gotQ[0] !== expQ[0]) begin bad++; $display("[TB] FAIL partial_write got=%h exp=%h", gotQ[0], expQ[0]); end
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL partial_busy got=%b exp=0", bus.busy); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL partial_done_pulses got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a;
    a = 8'h03;
    gotQ.delete();
    doneCnt = 0;
    @(negedge iclk);
    for (int b = W - 1; b >= 0; b--) sendBit(a[b]);
    for (int k = 0; k < 4; k++) sendBit(1'($urandom_range(0, 1)));
    bus.sclk = 1'b0;
    rst = 1'b1;
    repeat (SS + 3) @(negedge iclk);
    total++; if (bus.mux_control_signal !== '0) begin bad++; $display("[TB] FAIL midrst_mux got=%h exp=0", bus.mux_control_signal); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.write_addr !== '0 || bus.write_data !== '0) begin bad++; $display("[TB] FAIL midrst_write_bus got=%h/%h exp=0/0", bus.write_addr, bus.write_data); end
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_addr_err got=%b exp=0", bus.addr_err); end
    rst = 1'b0;
    repeat (TO + SS + 12) @(negedge iclk);
    total++; if (gotQ.size() != 0) begin bad++; $display("[TB] FAIL midrst_writes got=%0d exp=0", gotQ.size()); end
    total++; if (doneCnt != 0) begin bad++; $display("[TB] FAIL midrst_done_pulses got=%0d exp=0", doneCnt); end
  endtask

  task automatic test_random();
    int n;
    int extra;
    for (int f = 0; f < 10; f++) begin
      txWords.delete();
      txWords.push_back(W'($urandom_range(0, NR + 4)));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) txWords.push_back(W'($urandom_range(0, 255)));
      extra = $urandom_range(0, W - 1);
      applyStimulus(extra);
      buildExpect();
      total++; if (gotQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d exp=%0d", f, gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
        total++; if (gotQ[i] !== expQ[i]) begin bad++; $display("[TB] FAIL rand%0d_write%0d got=%h exp=%h", f, i, gotQ[i], expQ[i]); end
      end
      total++; if (bus.mux_control_signal !== W'(expMux)) begin bad++; $display("[TB] FAIL rand%0d_mux got=%h exp=%h", f, bus.mux_control_signal, W'(expMux)); end
      total++; if (bus.addr_err !== expErr) begin bad++; $display("[TB] FAIL rand%0d_addr_err got=%b exp=%b", f, bus.addr_err, expErr); end
      total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL rand%0d_done_pulses got=%0d exp=1", f, doneCnt); end
    end
  endtask

  initial begin
    bus.sclk      = 1'b0;
    bus.serial_in = 1'b0;
    doneCnt       = 0;
    test_reset();
    test_frame("basic", 8'h03, 8'hA5, 8'h5A);
    test_frame("wrap", 8'h0F, 8'h11, 8'h22);
    test_addr_err();
    test_partial();
    test_reset_mid();
    test_frame("after_rst", 8'h03, 8'hA5, 8'h5A);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
